// File: rtl/mul_unit.sv
// ============================================================================
// mul_unit -- iterative shift-add N x N multiplier (MUL / UMULH / SMULH)
//             delivering its result as a one-cycle register-file write.
// Revision: 1.0
// ============================================================================
`default_nettype none

module mul_unit #(
  parameter int N = 64
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start,
  input  logic [1:0]   op,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic [4:0]   wa,
  output logic         busy,
  output logic         we_out,
  output logic [4:0]   wa_out,
  output logic [N-1:0] wd_out
);

  localparam int         CW        = $clog2(N);
  localparam logic [1:0] C_OP_UMULH = 2'b01;
  localparam logic [1:0] C_OP_SMULH = 2'b10;
  localparam logic [4:0] C_XZR      = 5'd31;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t           r_state, w_next;
  logic [CW-1:0]    r_cnt;
  logic [1:0]       r_op;
  logic [4:0]       r_wa;
  logic             r_neg;
  logic [N-1:0]     r_mcand;
  logic [N-1:0]     r_hi;
  logic [N-1:0]     r_lo;
  logic             r_we;
  logic [4:0]       r_wa_out;
  logic [N-1:0]     r_wd;

  logic             w_smulh;
  logic [N-1:0]     w_abs_a;
  logic [N-1:0]     w_abs_b;
  logic [N:0]       w_sum;
  logic [2*N-1:0]   w_raw;
  logic [2*N-1:0]   w_prod;
  logic [N-1:0]     w_result;
  logic             w_last;

  assign w_smulh = (op == C_OP_SMULH);
  assign w_abs_a = a[N-1] ? ('0 - a) : a;
  assign w_abs_b = b[N-1] ? ('0 - b) : b;

  // Conditional add of the multiplicand keeps its carry so the shift below
  // brings it into acc_hi's MSB.
  assign w_sum    = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_mcand} : '0);
  assign w_raw    = {r_hi, r_lo};
  assign w_prod   = r_neg ? ('0 - w_raw) : w_raw;
  assign w_result = ((r_op == C_OP_UMULH) || (r_op == C_OP_SMULH)) ?
                    w_prod[2*N-1:N] : w_prod[N-1:0];
  assign w_last   = (r_cnt == CW'(N-1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_BUSY;
      S_BUSY:  if (w_last) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt    <= '0;
      r_op     <= '0;
      r_wa     <= '0;
      r_neg    <= 1'b0;
      r_mcand  <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_we     <= 1'b0;
      r_wa_out <= '0;
      r_wd     <= '0;
    end else begin
      r_we <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_op    <= op;
            r_wa    <= wa;
            r_neg   <= w_smulh & (a[N-1] ^ b[N-1]);
            r_mcand <= w_smulh ? w_abs_a : a;
            r_hi    <= '0;
            r_lo    <= w_smulh ? w_abs_b : b;
            r_cnt   <= '0;
          end
        end
        S_BUSY: begin
          r_hi  <= w_sum[N:1];
          r_lo  <= {w_sum[0], r_lo[N-1:1]};
          r_cnt <= r_cnt + 1'b1;
        end
        S_DONE: begin
          r_wd     <= w_result;
          r_wa_out <= r_wa;
          r_we     <= (r_wa != C_XZR);
        end
        default: ;
      endcase
    end
  end

  assign busy   = (r_state != S_IDLE);
  assign we_out = r_we;
  assign wa_out = r_wa_out;
  assign wd_out = r_wd;

endmodule

`default_nettype wire
